// File: rtl/tcm_dual_port_mem.sv
// Dual-port TCM: read-only fetch port plus byte-strobed data port.
// Optional TCM_ADDR_CHECK_EN flags out-of-range accesses as errors.
module tcm_dual_port_mem #(
  parameter int          MEM_ADDR_W = 14,
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int          TAG_W      = 11
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             mem_i_rd_i,
  input  logic             mem_i_flush_i,
  input  logic             mem_i_invalidate_i,
  input  logic [31:0]      mem_i_pc_i,
  output logic             mem_i_accept_o,
  output logic             mem_i_valid_o,
  output logic             mem_i_error_o,
  output logic [31:0]      mem_i_inst_o,
  input  logic [31:0]      mem_d_addr_i,
  input  logic [31:0]      mem_d_data_wr_i,
  input  logic             mem_d_rd_i,
  input  logic [3:0]       mem_d_wr_i,
  input  logic             mem_d_cacheable_i,
  input  logic [TAG_W-1:0] mem_d_req_tag_i,
  input  logic             mem_d_invalidate_i,
  input  logic             mem_d_writeback_i,
  input  logic             mem_d_flush_i,
  output logic [31:0]      mem_d_data_rd_o,
  output logic             mem_d_accept_o,
  output logic             mem_d_ack_o,
  output logic             mem_d_error_o,
  output logic [TAG_W-1:0] mem_d_resp_tag_o
);

  localparam int DEPTH = 1 << MEM_ADDR_W;

  logic [31:0]           ram [DEPTH];
  logic [MEM_ADDR_W-1:0] iidx;
  logic [MEM_ADDR_W-1:0] didx;
  logic                  d_req;
  logic                  d_acc;
  logic                  oor_i;
  logic                  oor_d;
  logic [3:0]            we;

  assign iidx  = mem_i_pc_i[MEM_ADDR_W+1:2];
  assign didx  = mem_d_addr_i[MEM_ADDR_W+1:2];
  assign d_acc = mem_d_rd_i | (|mem_d_wr_i);
  assign d_req = d_acc | mem_d_flush_i
               | mem_d_invalidate_i
               | mem_d_writeback_i;

`ifdef TCM_ADDR_CHECK_EN
  logic [31:0] ioff;
  logic [31:0] doff;

  assign ioff  = mem_i_pc_i - BASE_ADDR;
  assign doff  = mem_d_addr_i - BASE_ADDR;
  assign oor_i = |ioff[31:MEM_ADDR_W+2];
  assign oor_d = |doff[31:MEM_ADDR_W+2];
`else
  assign oor_i = 1'b0;
  assign oor_d = 1'b0;
`endif

  assign we = mem_d_wr_i & {4{~oor_d}};

  assign mem_i_accept_o = rst_i;
  assign mem_d_accept_o = rst_i;

  // RAM array has no reset so it maps onto plain SRAM macros
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) begin
        ram[didx][8*b +: 8] <= mem_d_data_wr_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem_i_valid_o <= 1'b0;
      mem_i_error_o <= 1'b0;
      mem_i_inst_o  <= '0;
    end else begin
      mem_i_valid_o <= mem_i_rd_i;
      mem_i_error_o <= mem_i_rd_i & oor_i;
      if (mem_i_rd_i) begin
        mem_i_inst_o <= oor_i ? '0 : ram[iidx];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem_d_ack_o      <= 1'b0;
      mem_d_error_o    <= 1'b0;
      mem_d_data_rd_o  <= '0;
      mem_d_resp_tag_o <= '0;
    end else begin
      mem_d_ack_o   <= d_req;
      mem_d_error_o <= d_acc & oor_d;
      if (d_req) begin
        mem_d_resp_tag_o <= mem_d_req_tag_i;
      end
      if (d_acc & oor_d) begin
        mem_d_data_rd_o <= '0;
      end else if (mem_d_rd_i) begin
        mem_d_data_rd_o <= ram[didx];
      end
    end
  end

  logic unused_ok;
  assign unused_ok = &{1'b0,
                       mem_i_flush_i,
                       mem_i_invalidate_i,
                       mem_d_cacheable_i,
                       mem_i_pc_i[1:0],
                       mem_d_addr_i[1:0],
                       mem_i_pc_i[31:MEM_ADDR_W+2],
                       mem_d_addr_i[31:MEM_ADDR_W+2]};

endmodule

// File: tb/tb_tcm_dual_port_mem.sv
// Directed bench for tcm_dual_port_mem.
// Build with or without TCM_ADDR_CHECK_EN.
module tb_tcm_dual_port_mem;

  localparam int TAG_W = 11;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             mem_i_rd_i;
  logic             mem_i_flush_i;
  logic             mem_i_invalidate_i;
  logic [31:0]      mem_i_pc_i;
  logic             mem_i_accept_o;
  logic             mem_i_valid_o;
  logic             mem_i_error_o;
  logic [31:0]      mem_i_inst_o;
  logic [31:0]      mem_d_addr_i;
  logic [31:0]      mem_d_data_wr_i;
  logic             mem_d_rd_i;
  logic [3:0]       mem_d_wr_i;
  logic             mem_d_cacheable_i;
  logic [TAG_W-1:0] mem_d_req_tag_i;
  logic             mem_d_invalidate_i;
  logic             mem_d_writeback_i;
  logic             mem_d_flush_i;
  logic [31:0]      mem_d_data_rd_o;
  logic             mem_d_accept_o;
  logic             mem_d_ack_o;
  logic             mem_d_error_o;
  logic [TAG_W-1:0] mem_d_resp_tag_o;

  int total = 0;
  int bad   = 0;

  tcm_dual_port_mem dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .mem_i_rd_i         (mem_i_rd_i),
    .mem_i_flush_i      (mem_i_flush_i),
    .mem_i_invalidate_i (mem_i_invalidate_i),
    .mem_i_pc_i         (mem_i_pc_i),
    .mem_i_accept_o     (mem_i_accept_o),
    .mem_i_valid_o      (mem_i_valid_o),
    .mem_i_error_o      (mem_i_error_o),
    .mem_i_inst_o       (mem_i_inst_o),
    .mem_d_addr_i       (mem_d_addr_i),
    .mem_d_data_wr_i    (mem_d_data_wr_i),
    .mem_d_rd_i         (mem_d_rd_i),
    .mem_d_wr_i         (mem_d_wr_i),
    .mem_d_cacheable_i  (mem_d_cacheable_i),
    .mem_d_req_tag_i    (mem_d_req_tag_i),
    .mem_d_invalidate_i (mem_d_invalidate_i),
    .mem_d_writeback_i  (mem_d_writeback_i),
    .mem_d_flush_i      (mem_d_flush_i),
    .mem_d_data_rd_o    (mem_d_data_rd_o),
    .mem_d_accept_o     (mem_d_accept_o),
    .mem_d_ack_o        (mem_d_ack_o),
    .mem_d_error_o      (mem_d_error_o),
    .mem_d_resp_tag_o   (mem_d_resp_tag_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    mem_i_rd_i         = 1'b0;
    mem_i_flush_i      = 1'b0;
    mem_i_invalidate_i = 1'b0;
    mem_i_pc_i         = '0;
    mem_d_addr_i       = '0;
    mem_d_data_wr_i    = '0;
    mem_d_rd_i         = 1'b0;
    mem_d_wr_i         = '0;
    mem_d_cacheable_i  = 1'b0;
    mem_d_req_tag_i    = '0;
    mem_d_invalidate_i = 1'b0;
    mem_d_writeback_i  = 1'b0;
    mem_d_flush_i      = 1'b0;
  endtask

  task automatic dwr(input logic [31:0] a,
                     input logic [31:0] d,
                     input logic [3:0]  s,
                     input logic [TAG_W-1:0] t);
    idle();
    mem_d_addr_i    = a;
    mem_d_data_wr_i = d;
    mem_d_wr_i      = s;
    mem_d_req_tag_i = t;
    tick();
  endtask

  task automatic drd(input logic [31:0] a,
                     input logic [TAG_W-1:0] t);
    idle();
    mem_d_addr_i    = a;
    mem_d_rd_i      = 1'b1;
    mem_d_req_tag_i = t;
    tick();
  endtask

  initial begin
    idle();
    rst_i = 1'b0;
    tick();
    tick();
    chk("rst_iacc", 32'(mem_i_accept_o), 0);
    chk("rst_dacc", 32'(mem_d_accept_o), 0);
    chk("rst_ival", 32'(mem_i_valid_o), 0);
    chk("rst_ierr", 32'(mem_i_error_o), 0);
    chk("rst_ack", 32'(mem_d_ack_o), 0);
    chk("rst_derr", 32'(mem_d_error_o), 0);
    chk("rst_inst", mem_i_inst_o, 0);
    chk("rst_drd", mem_d_data_rd_o, 0);
    chk("rst_tag", 32'(mem_d_resp_tag_o), 0);
    rst_i = 1'b1;
    #1;
    chk("rel_iacc", 32'(mem_i_accept_o), 1);
    chk("rel_dacc", 32'(mem_d_accept_o), 1);
    tick();

    dwr(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 11'h155);
    chk("wr_ack", 32'(mem_d_ack_o), 1);
    chk("wr_tag", 32'(mem_d_resp_tag_o), 32'h155);
    chk("wr_err", 32'(mem_d_error_o), 0);
    idle();
    mem_d_addr_i    = 32'h8000_0010;
    mem_d_rd_i      = 1'b1;
    mem_d_req_tag_i = 11'h2AA;
    mem_i_rd_i      = 1'b1;
    mem_i_pc_i      = 32'h8000_0010;
    tick();
    chk("rd_data", mem_d_data_rd_o, 32'hDEAD_BEEF);
    chk("rd_tag", 32'(mem_d_resp_tag_o), 32'h2AA);
    chk("if_val", 32'(mem_i_valid_o), 1);
    chk("if_inst", mem_i_inst_o, 32'hDEAD_BEEF);
    idle();
    tick();
    chk("idle_ack", 32'(mem_d_ack_o), 0);
    chk("idle_ival", 32'(mem_i_valid_o), 0);
    chk("inst_hold", mem_i_inst_o, 32'hDEAD_BEEF);

    dwr(32'h8000_0020, 32'h1122_3344, 4'hF, 11'h1);
    dwr(32'h8000_0020, 32'h0000_00AA, 4'b0001, 11'h2);
    drd(32'h8000_0020, 11'h3);
    chk("strb_lo", mem_d_data_rd_o, 32'h1122_33AA);
    dwr(32'h8000_0022, 32'h5566_0000, 4'b1100, 11'h4);
    drd(32'h8000_0020, 11'h5);
    chk("strb_hi", mem_d_data_rd_o, 32'h5566_33AA);

    dwr(32'h8000_0030, 32'hCAFE_F00D, 4'hF, 11'h6);
    idle();
    mem_d_addr_i    = 32'h8000_0030;
    mem_d_rd_i      = 1'b1;
    mem_d_wr_i      = 4'hF;
    mem_d_data_wr_i = 32'h1234_5678;
    mem_i_rd_i      = 1'b1;
    mem_i_pc_i      = 32'h8000_0030;
    tick();
    chk("rw_old", mem_d_data_rd_o, 32'hCAFE_F00D);
    chk("rw_if", mem_i_inst_o, 32'hCAFE_F00D);
    drd(32'h8000_0030, 11'h7);
    chk("rw_new", mem_d_data_rd_o, 32'h1234_5678);

    idle();
    mem_d_addr_i    = 32'h8000_0030;
    mem_d_flush_i   = 1'b1;
    mem_d_req_tag_i = 11'd3;
    tick();
    chk("fl_ack", 32'(mem_d_ack_o), 1);
    chk("fl_tag", 32'(mem_d_resp_tag_o), 3);
    chk("fl_hold", mem_d_data_rd_o, 32'h1234_5678);
    idle();
    mem_d_invalidate_i = 1'b1;
    mem_d_writeback_i  = 1'b1;
    mem_d_req_tag_i    = 11'h7FF;
    tick();
    chk("inv_ack", 32'(mem_d_ack_o), 1);
    chk("inv_tag", 32'(mem_d_resp_tag_o), 32'h7FF);
    drd(32'h8000_0030, 11'h8);
    chk("fl_ram", mem_d_data_rd_o, 32'h1234_5678);
    idle();
    mem_i_flush_i      = 1'b1;
    mem_i_invalidate_i = 1'b1;
    tick();
    chk("ifl_val", 32'(mem_i_valid_o), 0);
    chk("ifl_ack", 32'(mem_d_ack_o), 0);

    drd(32'h8000_0010, 11'h11);
    chk("b2b_t1", 32'(mem_d_resp_tag_o), 32'h11);
    chk("b2b_d1", mem_d_data_rd_o, 32'hDEAD_BEEF);
    drd(32'h8000_0020, 11'h22);
    chk("b2b_a2", 32'(mem_d_ack_o), 1);
    chk("b2b_t2", 32'(mem_d_resp_tag_o), 32'h22);
    chk("b2b_d2", mem_d_data_rd_o, 32'h5566_33AA);

    idle();
    mem_d_rd_i   = 1'b1;
    mem_d_addr_i = 32'h8000_0010;
    mem_i_rd_i   = 1'b1;
    mem_i_pc_i   = 32'h8000_0010;
    tick();
    rst_i = 1'b0;
    #1;
    chk("mid_ack", 32'(mem_d_ack_o), 0);
    chk("mid_ival", 32'(mem_i_valid_o), 0);
    idle();
    tick();
    rst_i = 1'b1;
    tick();
    chk("post_ack", 32'(mem_d_ack_o), 0);
    chk("post_ival", 32'(mem_i_valid_o), 0);

    dwr(32'h8000_0000, 32'h0BAD_F00D, 4'hF, 11'h30);
    dwr(32'h9000_0000, 32'hA5A5_A5A5, 4'hF, 11'h31);
    chk("oor_wack", 32'(mem_d_ack_o), 1);
`ifdef TCM_ADDR_CHECK_EN
    chk("oor_werr", 32'(mem_d_error_o), 1);
`else
    chk("oor_werr", 32'(mem_d_error_o), 0);
`endif
    drd(32'h9000_0000, 11'h32);
    chk("oor_rack", 32'(mem_d_ack_o), 1);
`ifdef TCM_ADDR_CHECK_EN
    chk("oor_rerr", 32'(mem_d_error_o), 1);
    chk("oor_rd", mem_d_data_rd_o, 0);
`else
    chk("oor_rerr", 32'(mem_d_error_o), 0);
    chk("oor_rd", mem_d_data_rd_o, 32'hA5A5_A5A5);
`endif
    drd(32'h8000_0000, 11'h33);
    chk("w0_err", 32'(mem_d_error_o), 0);
`ifdef TCM_ADDR_CHECK_EN
    chk("w0_data", mem_d_data_rd_o, 32'h0BAD_F00D);
`else
    chk("w0_data", mem_d_data_rd_o, 32'hA5A5_A5A5);
`endif
    idle();
    mem_i_rd_i = 1'b1;
    mem_i_pc_i = 32'h9000_0000;
    tick();
    chk("oor_ival", 32'(mem_i_valid_o), 1);
`ifdef TCM_ADDR_CHECK_EN
    chk("oor_ierr", 32'(mem_i_error_o), 1);
    chk("oor_inst", mem_i_inst_o, 0);
`else
    chk("oor_ierr", 32'(mem_i_error_o), 0);
    chk("oor_inst", mem_i_inst_o, 32'hA5A5_A5A5);
`endif
    idle();
    tick();
    chk("err_clr_i", 32'(mem_i_error_o), 0);
    chk("err_clr_d", 32'(mem_d_error_o), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tcm_dual_port_mem.md
Name: tcm_dual_port_mem

Overview:
Tightly-coupled dual-port SRAM serving the riscv core. One read-only instruction-fetch port and one read/write data port with byte strobes. Fixed 1-cycle response latency on both ports, no back-pressure. Cache-maintenance requests are acknowledged as no-ops because the memory is uncached.

Parameters:
MEM_ADDR_W, 14, word-address width; capacity = 2^MEM_ADDR_W 32-bit words (default 64 KB)
BASE_ADDR, 32'h80000000, byte address of word 0; matches core reset vector
TAG_W, 11, width of data request/response tag

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  asynchronous active-low reset
mem_i_rd_i  in  1  instruction fetch request
mem_i_flush_i  in  1  fetch-side flush; ignored
mem_i_invalidate_i  in  1  fetch-side invalidate; ignored
mem_i_pc_i  in  32  fetch byte address, word aligned
mem_i_accept_o  out  1  fetch request accepted
mem_i_valid_o  out  1  instruction valid
mem_i_error_o  out  1  fetch error
mem_i_inst_o  out  32  fetched instruction
mem_d_addr_i  in  32  data byte address, word aligned
mem_d_data_wr_i  in  32  write data
mem_d_rd_i  in  1  data read request
mem_d_wr_i  in  4  byte write strobes; bit n writes bits [8n+7:8n]
mem_d_cacheable_i  in  1  ignored
mem_d_req_tag_i  in  TAG_W  request tag
mem_d_invalidate_i  in  1  cache invalidate request
mem_d_writeback_i  in  1  cache writeback request
mem_d_flush_i  in  1  cache flush request
mem_d_data_rd_o  out  32  read data
mem_d_accept_o  out  1  data request accepted
mem_d_ack_o  out  1  data response valid
mem_d_error_o  out  1  data error
mem_d_resp_tag_o  out  TAG_W  echoed tag

Behaviour:
- Reset (rst_i=0, async): mem_i_valid_o, mem_i_error_o, mem_d_ack_o, mem_d_error_o = 0; mem_i_inst_o, mem_d_data_rd_o = 0; mem_d_resp_tag_o = 0. RAM contents are not cleared.
- mem_i_accept_o and mem_d_accept_o = 1 whenever rst_i=1, 0 during reset. A request is taken every cycle its strobe is high.
- Word index = addr[MEM_ADDR_W+1:2]. Bits [1:0] are ignored. Upper bits alias unless the optional feature is enabled.
- Fetch: mem_i_rd_i high at edge N gives mem_i_valid_o=1 and mem_i_inst_o = RAM[index] during cycle N+1. valid is 0 when no request. inst holds its last value when valid=0.
- Data request: any of rd, |wr, flush, invalidate, writeback high at edge N gives mem_d_ack_o=1 for exactly cycle N+1, with mem_d_resp_tag_o = tag sampled at N.
- Write: selected bytes are updated at edge N; unselected bytes are unchanged.
- Read: mem_d_data_rd_o = RAM[index] as of before edge N (read-first). This also applies when rd and wr are high together, in which case the write still occurs.
- Flush/invalidate/writeback only: ack, data_rd_o unchanged, no RAM change.
- Fetch and data port may target the same word in the same cycle. The fetch returns the pre-write value.
- Back-to-back requests: one ack per request cycle, pipelined, no bubbles.
- Reset mid-operation: a pending response is dropped (no ack/valid after reset release until a new request).
- mem_i_error_o and mem_d_error_o are 0 unless the optional feature is enabled.

Optional Feature:
TCM_ADDR_CHECK_EN
- Defined: an address is out of range when (addr - BASE_ADDR) >= 2^(MEM_ADDR_W+2). Out-of-range fetch gives valid=1, error=1, inst=0. Out-of-range data access gives ack=1, error=1, data_rd=0, and the write is suppressed. Both errors are single-cycle, aligned with the response.
- Undefined: error outputs are tied 0 and addresses alias modulo capacity.

Test Plan:
1. Reset then release. Required: all valid/ack/error = 0, accepts = 0 in reset, accepts = 1 after release.
2. Write 0xDEADBEEF, wr=4'hF at 0x80000010. Next cycle: ack=1 with tag echoed (e.g. 11'h155). Then read 0x80000010: data_rd=0xDEADBEEF one cycle later; fetch pc=0x80000010 gives valid=1, inst=0xDEADBEEF.
3. Write 0x000000AA with wr=4'b0001 over 0x11223344. Readback 0x112233AA. Then wr=4'b1100 with 0x5566xxxx gives 0x556633AA.
4. rd=1 and wr=4'hF, data 0x12345678, to a word holding 0xCAFEF00D in the same cycle. Response data 0xCAFEF00D; a following read returns 0x12345678. A concurrent fetch of that word also returns 0xCAFEF00D.
5. Flush=1 alone, tag 3. Next cycle ack=1, resp_tag=3, RAM unchanged. mem_i_flush_i/invalidate_i pulses cause no valid.
6. With TCM_ADDR_CHECK_EN, write to 0x90000000 then read it. Both give ack=1, error=1, read data 0. Word 0 is unchanged. Without the macro, the same addresses alias to word 0.
